// File: rtl/nn_pkg.sv
// nn_pkg: ALU op codes and sequencer FSM state type shared by the NN datapath blocks
package nn_pkg;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_MUL  = 3'b001,
    ALU_SNN  = 3'b010,
    ALU_PASS = 3'b111
  } alu_op_e;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MUL   = 3'd2,
    S_ACC   = 3'd3,
    S_ACT   = 3'd4,
    S_DONE  = 3'd5
  } state_e;
endpackage

// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer: drives an external ALU through fetch/multiply/accumulate per element, then a step activation
module dot_product_sequencer
  import nn_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [NBITS-1:0]  w_data,
  input  logic [NBITS-1:0]  x_data,
  output logic [2:0]        alu_ctrl,
  output logic [NBITS-1:0]  alu_src_a,
  output logic [NBITS-1:0]  alu_src_b,
  input  logic [NBITS-1:0]  alu_result,
  output logic              busy,
  output logic              done,
  output logic [NBITS-1:0]  result,
  output logic              fire
);
  localparam logic [ADDR_W:0] NMAX = (ADDR_W+1)'(2**ADDR_W);
  state_e            state, state_n;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   eff_len;
  logic [NBITS-1:0]  acc, prod;
  logic              last;
  assign last = {1'b0, idx} == eff_len - 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? (len == '0 ? S_DONE : S_FETCH) : S_IDLE;
      S_FETCH: state_n = S_MUL;
      S_MUL:   state_n = S_ACC;
      S_ACC:   state_n = last ? S_ACT : S_FETCH;
      S_ACT:   state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  always_comb begin
    busy      = state != S_IDLE;
    done      = state == S_DONE;
    rd_en     = state == S_FETCH;
    rd_addr   = idx;
    alu_ctrl  = state == S_MUL ? ALU_MUL : state == S_ACC ? ALU_ADD : state == S_ACT ? ALU_SNN : ALU_PASS;
    alu_src_a = state == S_MUL ? w_data : (state == S_ACC || state == S_ACT) ? acc : '0;
    alu_src_b = state == S_MUL ? x_data : state == S_ACC ? prod : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx     <= '0;
      eff_len <= '0;
      acc     <= '0;
      prod    <= '0;
      result  <= '0;
      fire    <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (start) begin
            idx     <= '0;
            acc     <= '0;
            eff_len <= len > NMAX ? NMAX : len;
            if (len == '0) begin
              result <= '0;
              fire   <= 1'b1;
            end
          end
        S_MUL: prod <= alu_result;
        S_ACC: begin
          acc <= alu_result;
          if (!last) idx <= idx + 1'b1;
        end
        S_ACT: begin
          fire   <= alu_result[0];
          result <= acc;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb_dot_product_sequencer: randomized and directed dot products against an arithmetic reference model
module tb_dot_product_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  len = '0;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] w_data = '0, x_data = '0;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_src_a, alu_src_b, alu_result;
  logic        busy, done, fire;
  logic [31:0] result;
  logic [31:0] w_mem [16];
  logic [31:0] x_mem [16];
  int          rd_log [$];
  int          vectors = 0;
  int          miscompares = 0;
  dot_product_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .rd_en(rd_en), .rd_addr(rd_addr), .w_data(w_data), .x_data(x_data),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_result(alu_result), .busy(busy), .done(done), .result(result), .fire(fire)
  );
  always #5 clk = ~clk;
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = alu_src_a + alu_src_b;
      3'b001:  alu_result = alu_src_a * alu_src_b;
      3'b010:  alu_result = ($signed(alu_src_a) >= $signed(alu_src_b)) ? 32'd1 : 32'd0;
      default: alu_result = alu_src_a;
    endcase
  end
  always @(posedge clk) begin
    if (rd_en) begin
      w_data <= w_mem[rd_addr];
      x_data <= x_mem[rd_addr];
      rd_log.push_back(int'(rd_addr));
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input string name, input int n, input int poke);
    int          eff, edc, cyc;
    logic [31:0] er;
    logic        ef;
    eff = n > 16 ? 16 : n;
    er  = '0;
    for (int i = 0; i < eff; i++) er += w_mem[i] * x_mem[i];
    ef  = $signed(er) >= 0;
    edc = eff == 0 ? 1 : 3 * eff + 2;
    @(negedge clk);
    rd_log.delete();
    len   = 5'(n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      if (cyc == poke) begin
        start = 1'b1;
        len   = 5'd7;
      end
      @(posedge clk);
      #1 start = 1'b0;
      cyc++;
    end
    check({name, ".done_cycle"}, 64'(cyc), 64'(edc));
    check({name, ".result"}, 64'(result), 64'(er));
    check({name, ".fire"}, 64'(fire), 64'(ef));
    check({name, ".reads"}, 64'(rd_log.size()), 64'(eff));
    for (int i = 0; i < rd_log.size() && i < 16; i++)
      check($sformatf("%s.addr%0d", name, i), 64'(rd_log[i]), 64'(i));
    @(posedge clk);
    #1;
    check({name, ".done_pulse"}, 64'(done), 64'(0));
    check({name, ".idle"}, 64'(busy), 64'(0));
  endtask
  task automatic load_basic();
    w_mem[0] = 32'd1; w_mem[1] = 32'd2; w_mem[2] = 32'd3;
    x_mem[0] = 32'd4; x_mem[1] = 32'd5; x_mem[2] = 32'd6;
  endtask
  initial begin
    int seen;
    for (int i = 0; i < 16; i++) begin
      w_mem[i] = '0;
      x_mem[i] = '0;
    end
    #2;
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.rd_en", 64'(rd_en), 64'(0));
    check("rst.alu_ctrl", 64'(alu_ctrl), 64'(3'b111));
    check("rst.result", 64'(result), 64'(0));
    check("rst.fire", 64'(fire), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    load_basic();
    run("basic", 3, 0);
    w_mem[0] = 32'hFFFF_FFFE; w_mem[1] = 32'd1;
    x_mem[0] = 32'd3;         x_mem[1] = 32'd1;
    run("negative", 2, 0);
    run("zero_len", 0, 0);
    w_mem[0] = 32'h7FFF_FFFF; x_mem[0] = 32'd2;
    run("wrap", 1, 0);
    for (int i = 0; i < 16; i++) begin
      w_mem[i] = $urandom_range(0, 200) - 100;
      x_mem[i] = $urandom_range(0, 200) - 100;
    end
    run("long", 20, 0);
    run("ignored_start", 2, 2);
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) begin
        w_mem[i] = t[0] ? $urandom() : $urandom_range(0, 1000) - 500;
        x_mem[i] = t[0] ? $urandom() : $urandom_range(0, 1000) - 500;
      end
      run($sformatf("rand%0d", t), $urandom_range(0, 20), 0);
    end
    load_basic();
    @(negedge clk);
    len   = 5'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    for (int c = 1; c < 5; c++) begin
      if (c == 2) start = 1'b1;
      if (done) seen = 1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("abort.busy", 64'(busy), 64'(0));
    check("abort.done", 64'(done), 64'(0));
    check("abort.rd_en", 64'(rd_en), 64'(0));
    check("abort.alu_ctrl", 64'(alu_ctrl), 64'(3'b111));
    check("abort.result", 64'(result), 64'(0));
    check("abort.fire", 64'(fire), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1;
    end
    check("abort.no_done", 64'(seen), 64'(0));
    run("rerun", 3, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
